cpri_txdata_pack_4ant: RTL and testbench

//  UL-side CPRI transmit packer for one 4-antenna group; the counterpart of the DL-side 4-antenna CPRI rx unpacker.

---
 rtl/cpri_txdata_pack_4ant_if.sv | 24 ++
 rtl/cpri_txdata_pack_4ant.sv | 165 ++++++++++++++++
 tb/tb_cpri_txdata_pack_4ant.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpri_txdata_pack_4ant_if.sv
// Port bundle for cpri_txdata_pack_4ant: compressed RE input side and CPRI word output side.
// i_tx_hold pins the transmit FSM in IDLE so the FIFO can be filled without draining.
interface cpri_txdata_pack_4ant_if;
  logic        i_vld;
  logic        i_sos;
  logic        i_eos;
  logic [55:0] i_iq;
  logic [15:0] i_shift;
  logic        i_tx_hold;
  logic [63:0] o_cpri_tx_data;
  logic [6:0]  o_cpri_tx_seq;
  logic        o_cpri_tx_vld;
  logic        o_overflow;

  modport master (
    output i_vld, i_sos, i_eos, i_iq, i_shift, i_tx_hold,
    input  o_cpri_tx_data, o_cpri_tx_seq, o_cpri_tx_vld, o_overflow
  );

  modport slave (
    input  i_vld, i_sos, i_eos, i_iq, i_shift, i_tx_hold,
    output o_cpri_tx_data, o_cpri_tx_seq, o_cpri_tx_vld, o_overflow
  );
endinterface

// File: rtl/cpri_txdata_pack_4ant.sv
// 4-antenna CPRI tx packer: BFP-compressed REs -> 64-bit words -> gap-free 96-word bursts.
// First word 2 cycles after the burst threshold; no input backpressure, REs hitting a full FIFO are dropped.

module cpri_pack_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 256
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_wdat,
  input  logic                   i_rd,
  output logic [W-1:0]           o_rdat,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_wr) mem[wr_ptr] <= i_wdat;
    if (i_rd) o_rdat <= mem[rd_ptr];
  end

  // Caller qualifies i_wr/i_rd against full/empty; pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_wr) wr_ptr <= wr_ptr + AW'(1);
      if (i_rd) rd_ptr <= rd_ptr + AW'(1);
      o_count <= o_count + (AW+1)'(i_wr) - (AW+1)'(i_rd);
    end
  end
endmodule

module cpri_txdata_pack_4ant #(
  parameter int BURST_LEN  = 96,
  parameter int FIFO_DEPTH = 256
) (
  input logic                     i_clk,
  input logic                     i_reset,
  cpri_txdata_pack_4ant_if.slave  bus
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST_CNT = (AW+1)'(BURST_LEN);
  localparam logic [6:0]  LAST_SEQ  = 7'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, PAD} state_t;

  state_t      state;
  logic [6:0]  seq;
  logic        flush_pend;
  logic        pad_wr;
  logic [3:0]  re_cnt;
  logic [3:0]  cur_re;
  logic [15:0] shift_q;
  logic [15:0] sh_src;
  logic [3:0]  sh_sel;
  logic [63:0] wr_word;
  logic [63:0] rd_word;
  logic [AW:0] count;
  logic [AW:0] count_nxt;
  logic        wr_ok;
  logic        rd_en;
  logic        eos_in;
  logic        s1_vld;
  logic        s1_rd;
  logic [6:0]  s1_seq;

  always_comb begin
    cur_re    = bus.i_sos ? 4'd0 : re_cnt;
    // The first RE of an RB uses the live shift, since shift_q only updates at the edge.
    sh_src    = (cur_re == 4'd0) ? bus.i_shift : shift_q;
    sh_sel    = (cur_re < 4'd4) ? sh_src[{cur_re[1:0], 2'b00} +: 4] : 4'd0;
    wr_word   = {sh_sel, cur_re, bus.i_iq};
    rd_en     = (state != IDLE) && (count != '0);
    wr_ok     = bus.i_vld && ((count != FULL_CNT) || rd_en);
    count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_en);
    eos_in    = bus.i_vld && bus.i_eos;
  end

  cpri_pack_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (wr_ok),
    .i_wdat  (wr_word),
    .i_rd    (rd_en),
    .o_rdat  (rd_word),
    .o_count (count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      re_cnt         <= '0;
      shift_q        <= '0;
      bus.o_overflow <= 1'b0;
    end else if (bus.i_vld) begin
      re_cnt <= (cur_re == 4'd11) ? 4'd0 : cur_re + 4'd1;
      if (cur_re == 4'd0) shift_q <= bus.i_shift;
      if (!wr_ok) bus.o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state              <= IDLE;
      seq                <= '0;
      flush_pend         <= 1'b0;
      pad_wr             <= 1'b0;
      s1_vld             <= 1'b0;
      s1_rd              <= 1'b0;
      s1_seq             <= '0;
      bus.o_cpri_tx_vld  <= 1'b0;
      bus.o_cpri_tx_seq  <= '0;
      bus.o_cpri_tx_data <= '0;
    end else begin
      // Stage 1 lines up with the FIFO's registered read; stage 2 is the output register.
      s1_vld             <= (state != IDLE);
      s1_rd              <= rd_en;
      s1_seq             <= seq;
      bus.o_cpri_tx_vld  <= s1_vld;
      bus.o_cpri_tx_seq  <= s1_vld ? s1_seq : '0;
      bus.o_cpri_tx_data <= (s1_vld && s1_rd) ? rd_word : '0;

      if (eos_in) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          seq    <= '0;
          pad_wr <= 1'b0;
          if (!bus.i_tx_hold) begin
            if (count_nxt >= BURST_CNT)                state <= BURST;
            else if (flush_pend && count_nxt != '0)   state <= PAD;
            else if (flush_pend && !eos_in)           flush_pend <= 1'b0;
          end
        end
        BURST: begin
          if (seq == LAST_SEQ) begin
            seq <= '0;
            if (count_nxt < BURST_CNT) state <= IDLE;
          end else begin
            seq <= seq + 7'd1;
          end
        end
        PAD: begin
          if (bus.i_vld) pad_wr <= 1'b1;
          if (seq == LAST_SEQ) begin
            seq   <= '0;
            state <= IDLE;
            if (count_nxt == '0 && !pad_wr && !bus.i_vld) flush_pend <= 1'b0;
          end else begin
            seq <= seq + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpri_txdata_pack_4ant.sv
// Self-checking bench for cpri_txdata_pack_4ant: per-cycle output capture, queue-based word model,
// burst/sequence continuity checks and a small table of header-nibble expectations.
module tb_cpri_txdata_pack_4ant;
  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  cpri_txdata_pack_4ant_if bus();

  cpri_txdata_pack_4ant dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    logic        vld;
    logic [6:0]  seq;
    logic [63:0] dat;
  } obs_t;

  typedef struct {
    int         idx;
    logic [3:0] exp_sh;
    logic [3:0] exp_re;
  } vec_t;

  obs_t        obs[$];
  logic [63:0] exp_q[$];
  logic [63:0] gotw[$];
  vec_t        tv[11];

  int          tests = 0;
  int          fails = 0;
  int          m_next;
  logic [15:0] m_shift;
  int          w0, t_thr, first, rb, n;
  bit          found;
  logic [15:0] sh;
  logic [63:0] w;

  always @(negedge i_clk)
    obs.push_back('{bus.o_cpri_tx_vld, bus.o_cpri_tx_seq, bus.o_cpri_tx_data});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [55:0] rnd56();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[55:0];
  endfunction

  // Model: RE index follows sos/+1 mod 12, shifts latched on RE 0, accepted words queue in order.
  task automatic drive_re(input logic sos, input logic eos, input logic [15:0] shv,
                          input logic [55:0] iq, input bit accept);
    int         cur;
    logic [3:0] nib;
    bus.i_vld   = 1'b1;
    bus.i_sos   = sos;
    bus.i_eos   = eos;
    bus.i_shift = shv;
    bus.i_iq    = iq;
    cur    = sos ? 0 : m_next;
    m_next = (cur + 1) % 12;
    if (cur == 0) m_shift = shv;
    nib = (cur < 4) ? 4'((m_shift >> (4 * cur)) & 16'hF) : 4'd0;
    if (accept) exp_q.push_back({nib, 4'(cur), iq});
    @(posedge i_clk); #1;
    bus.i_vld = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.i_vld   = 1'b0;
      bus.i_sos   = 1'($urandom);
      bus.i_eos   = 1'($urandom);
      bus.i_iq    = rnd56();
      bus.i_shift = 16'($urandom);
      @(posedge i_clk); #1;
    end
  endtask

  // Bursts: seq 0..95 with no vld gap; each slot carries the next modelled word, or 0 once exhausted.
  task automatic check_window(input int start, input int exp_bursts, input int exp_last,
                              input string nm);
    int          exp_seq, seq_err, gap_err, idle_err, dat_err, last_cnt, nw;
    logic [63:0] e;
    exp_seq = 0; seq_err = 0; gap_err = 0; idle_err = 0; dat_err = 0; last_cnt = 0;
    gotw.delete();
    for (int i = start; i < obs.size(); i++) begin
      if (obs[i].vld) begin
        if (int'(obs[i].seq) != exp_seq) seq_err++;
        exp_seq = (exp_seq + 1) % 96;
        gotw.push_back(obs[i].dat);
      end else begin
        if (exp_seq != 0) gap_err++;
        if (obs[i].seq != 0 || obs[i].dat != 0) idle_err++;
        exp_seq = 0;
      end
    end
    nw = gotw.size();
    for (int i = 0; i < nw; i++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      if (gotw[i] !== e) dat_err++;
      if (i >= nw - 96 && gotw[i] != 0) last_cnt++;
    end
    chk({nm, "_words"},     64'(nw),          64'(exp_bursts * 96));
    chk({nm, "_seq_err"},   64'(seq_err),     64'd0);
    chk({nm, "_vld_gap"},   64'(gap_err),     64'd0);
    chk({nm, "_idle_out"},  64'(idle_err),    64'd0);
    chk({nm, "_data_err"},  64'(dat_err),     64'd0);
    chk({nm, "_leftover"},  64'(exp_q.size()), 64'd0);
    chk({nm, "_last_data"}, 64'(last_cnt),    64'(exp_last));
    exp_q.delete();
  endtask

  initial begin
    // RB r, antenna a carries shift r+a+1 in the hand-built burst.
    tv[0]  = '{0,  4'd1,  4'd0};
    tv[1]  = '{1,  4'd2,  4'd1};
    tv[2]  = '{2,  4'd3,  4'd2};
    tv[3]  = '{3,  4'd4,  4'd3};
    tv[4]  = '{4,  4'd0,  4'd4};
    tv[5]  = '{11, 4'd0,  4'd11};
    tv[6]  = '{12, 4'd2,  4'd0};
    tv[7]  = '{15, 4'd5,  4'd3};
    tv[8]  = '{16, 4'd0,  4'd4};
    tv[9]  = '{87, 4'd11, 4'd3};
    tv[10] = '{95, 4'd0,  4'd11};

    bus.i_vld = 1'b0; bus.i_sos = 1'b0; bus.i_eos = 1'b0;
    bus.i_iq = '0; bus.i_shift = '0; bus.i_tx_hold = 1'b0;
    m_next = 0; m_shift = '0;

    // Reset held 10 cycles while inputs toggle: nothing may get through.
    i_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_vld = 1'b1; bus.i_eos = 1'b1; bus.i_iq = rnd56();
      @(posedge i_clk); #1;
    end
    bus.i_vld = 1'b0; bus.i_eos = 1'b0;
    chk("rst_vld",      64'(bus.o_cpri_tx_vld),  64'd0);
    chk("rst_seq",      64'(bus.o_cpri_tx_seq),  64'd0);
    chk("rst_data",     bus.o_cpri_tx_data,      64'd0);
    chk("rst_overflow", 64'(bus.o_overflow),     64'd0);
    chk("rst_count",    64'(dut.count),          64'd0);
    i_reset = 1'b0;
    idle(3);

    // One burst; shift bus carries junk except on RE 0 of each RB.
    w0 = obs.size();
    for (int k = 0; k < 96; k++) begin
      rb = k / 12;
      if (k % 12 == 0) sh = {4'(rb + 4), 4'(rb + 3), 4'(rb + 2), 4'(rb + 1)};
      else sh = 16'($urandom);
      drive_re(k == 0, 1'b0, sh, rnd56(), 1'b1);
    end
    t_thr = obs.size();
    idle(200);
    first = -1;
    for (int i = w0; i < obs.size(); i++)
      if (obs[i].vld) begin
        first = i;
        break;
      end
    chk("t2_latency", 64'(first - t_thr), 64'd2);
    check_window(w0, 1, 96, "t2");
    for (int k = 0; k < 11; k++) begin
      w = (tv[k].idx < gotw.size()) ? gotw[tv[k].idx] : 64'hx;
      chk($sformatf("t2_hdr_w%0d", tv[k].idx), 64'(w[63:56]), 64'({tv[k].exp_sh, tv[k].exp_re}));
    end

    // Full 132-PRB symbol: 16 full bursts plus one padded burst.
    w0 = obs.size();
    for (int k = 0; k < 1584; k++)
      drive_re(k == 0, k == 1583, 16'($urandom), rnd56(), 1'b1);
    idle(300);
    check_window(w0, 17, 48, "t3");
    chk("t3_flush_pend", 64'(dut.flush_pend), 64'd0);
    chk("t3_overflow",   64'(bus.o_overflow), 64'd0);

    // 50% duty input, a mid-stream sos, eos on the last RE.
    w0 = obs.size();
    n = 0;
    while (n < 300) begin
      if ($urandom % 2 == 0) begin
        drive_re(n == 0 || n == 150, n == 299, 16'($urandom), rnd56(), 1'b1);
        n++;
      end else begin
        idle(1);
      end
    end
    idle(400);
    check_window(w0, 4, 12, "t4");
    chk("t4_overflow", 64'(bus.o_overflow), 64'd0);

    // FIFO fill with the tx side held; the 257th RE (carrying eos) is dropped.
    bus.i_tx_hold = 1'b1;
    idle(2);
    w0 = obs.size();
    for (int k = 0; k < 256; k++)
      drive_re(k == 0, 1'b0, 16'($urandom), rnd56(), 1'b1);
    chk("t5_ovf_before", 64'(bus.o_overflow), 64'd0);
    drive_re(1'b0, 1'b1, 16'($urandom), rnd56(), 1'b0);
    chk("t5_ovf_after",  64'(bus.o_overflow), 64'd1);
    chk("t5_count_full", 64'(dut.count),      64'd256);
    idle(5);
    chk("t5_held_vld",   64'(bus.o_cpri_tx_vld), 64'd0);
    bus.i_tx_hold = 1'b0;
    idle(400);
    check_window(w0, 3, 64, "t5");
    chk("t5_ovf_sticky", 64'(bus.o_overflow), 64'd1);

    // Reset in the middle of a burst.
    for (int k = 0; k < 96; k++)
      drive_re(k == 0, 1'b0, 16'($urandom), rnd56(), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (bus.o_cpri_tx_vld && bus.o_cpri_tx_seq == 7'd40) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_seq40_seen", 64'(found), 64'd1);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("t6_rst_vld",  64'(bus.o_cpri_tx_vld), 64'd0);
    chk("t6_rst_data", bus.o_cpri_tx_data,     64'd0);
    chk("t6_rst_seq",  64'(bus.o_cpri_tx_seq), 64'd0);
    idle(3);
    chk("t6_rst_ovf",  64'(bus.o_overflow),    64'd0);
    i_reset = 1'b0;
    m_next = 0;
    exp_q.delete();
    w0 = obs.size();
    for (int k = 0; k < 96; k++)
      drive_re(k == 0, 1'b0, 16'($urandom), rnd56(), 1'b1);
    idle(200);
    check_window(w0, 1, 96, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
